mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that sits on the core's data master bus, next to data_memory, and consumes store traffic in its address window.
- Stores to TXDATA push bytes into an internal FIFO.
- A bit-timing state machine serialises bytes onto a single tx line: 8N1, LSB first.
- Loads return status so firmware can poll before writing.

Parameters:
BASE, 'h2000, byte base address of the 3-register window (word-aligned).
AW, 32, address width.
DW, 32, data width.
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥2.
FIFO_DEPTH, 8, TX FIFO entries; power of 2, ≥2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  synchronous, active-low reset; sampled on rising clk.
address  input  AW  byte address from core data master.
read  input  1  load strobe (MemRead).
write  input  1  store strobe (MemWrite).
wdata  input  DW  store data.
rdata  output  DW  load data; combinational.
tx  output  1  serial output; idle high.

Behaviour:
Register map:
- hit = address in [BASE, BASE+12); word offset = address[3:2]; address[1:0] ignored.
- TXDATA (BASE+0):
  - write pushes wdata[7:0].
  - read returns 0.
- STATUS (BASE+4), read:
  - bit0 full.
  - bit1 empty.
  - bit2 busy (FSM not IDLE).
  - bit3 overflow, sticky.
  - bits[15:8] FIFO count, zero-extended.
  - all other bits 0.
  - A write with wdata[3]=1 clears overflow; other bits are ignored.
- CTRL (BASE+8): bit0 enable, reset value 1.
  - Write updates enable from wdata[0].
  - Read returns {31'b0, enable}.
- rdata = selected register when read && hit; else 0.
- Writes outside the window, or with write=0, have no effect.

Reset (reset_n=0 at a rising edge):
- FIFO emptied; count=0; overflow=0; enable=1.
- FSM=IDLE; tx=1; baud and bit counters = 0.
- Applies mid-frame: tx returns high at that edge; the partial frame is abandoned.

FIFO:
- Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
- count range 0..FIFO_DEPTH.
- Push accepted when count<FIFO_DEPTH, or when a pop occurs on the same edge.
- Otherwise the byte is dropped and overflow is set.
- Simultaneous push and pop: count unchanged, both pointers advance.

FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If enable && !empty at an edge: pop head into shift register, baud counter=0, go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit.
  - After bit index 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; the state or bit advances on the edge where counter==CLKS_PER_BIT-1.
- tx is registered (driven from a flop, not decoded combinationally).

Timing:
- Store to TXDATA sampled at edge N, FIFO previously empty, FSM IDLE, enable=1:
  - count=1 after edge N.
  - Pop and START at edge N+1.
  - tx low after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames have exactly one IDLE cycle between the end of STOP and START.
- Clearing enable mid-frame: the current frame completes; no further pops until enable=1.
- A push and a STATUS read in the same cycle: the read returns pre-edge state.

Test Plan:
1. Reset, then read STATUS (CLKS_PER_BIT=4) → rdata=32'h0000_0002 (empty=1); read CTRL → 1; tx=1.
2. Store 8'hA5 to BASE+0 → tx low 1 cycle after the push edge. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 then stop=1. Frame lasts 40 cycles. busy=1 during the frame, 0 after.
3. With enable=0, store 9 bytes (DEPTH=8) → STATUS count=8, full=1, overflow=1 (rdata=32'h0000_0809). Write STATUS with wdata=8 → overflow=0, count still 8.
4. Set enable=1 with 8 queued bytes → 8 frames, each 40 cycles, separated by exactly 1 idle cycle. Final STATUS empty=1, busy=0. Byte order matches push order, including correct FIFO pointer wrap.
5. Assert reset_n=0 for one edge mid-DATA → tx=1, count=0, FSM IDLE at that edge. No further transmission.
6. With FIFO full and the FSM popping on the same edge as a store, capture on the following edge → byte accepted, overflow stays 0, count stays 8. Also: a read at BASE+12 or BASE-4 → rdata=0, and a store there has no effect.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
// Purpose: groups the data-master load/store signals that the core presents
//          to memory-mapped peripherals such as mmio_uart_tx.
// Signals:
//   address  byte address from the core data master (AW bits)
//   read     load strobe (MemRead)
//   write    store strobe (MemWrite)
//   wdata    store data (DW bits)
//   rdata    load data returned by the peripheral (DW bits, combinational)
// Modports:
//   master   the core side: drives address/read/write/wdata, receives rdata
//   slave    the peripheral side: receives the request, drives rdata
interface mmio_uart_tx_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (
        output address,
        output read,
        output write,
        output wdata,
        input  rdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Purpose: memory-mapped UART transmitter (8N1, LSB first). Stores to TXDATA
//          queue bytes in a small FIFO; a bit-timing state machine drains the
//          FIFO onto the tx line. Loads return status for firmware polling.
// Register window (byte offsets from BASE):
//   +0 TXDATA  write pushes wdata[7:0]; reads as 0
//   +4 STATUS  {16'b0, count[7:0], 4'b0, overflow, busy, empty, full};
//              writing wdata[3]=1 clears the sticky overflow flag
//   +8 CTRL    bit0 enable (resets to 1)
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset_n  synchronous active-low reset
//   bus      slave side of the data-master bus (address/read/write/wdata/rdata)
//   tx       registered serial output, idle high
module mmio_uart_tx #(
    parameter int unsigned BASE         = 'h2000,
    parameter int          AW           = 32,
    parameter int          DW           = 32,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    mmio_uart_tx_if.slave    bus,
    output logic             tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [AW-1:0] BASE_A    = AW'(BASE);
    localparam logic [AW-1:0] END_A     = AW'(BASE + 12);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [AW-1:0] rel_addr;
    logic          hit;
    logic [1:0]    word_off;
    logic          sel_txdata;
    logic          sel_status;
    logic          sel_ctrl;
    logic          unused_bits;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          enable;

    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic [31:0]   status_word;

    state_t        state;
    state_t        state_n;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic          tx_reg;
    logic          tx_n;

    // Address decode. The word offset is taken relative to BASE so the
    // window works for any word-aligned base, not only 16-byte aligned ones.
    assign rel_addr    = bus.address - BASE_A;
    assign hit         = (bus.address >= BASE_A) && (bus.address < END_A);
    assign word_off    = rel_addr[3:2];
    assign sel_txdata  = hit && (word_off == 2'd0);
    assign sel_status  = hit && (word_off == 2'd1);
    assign sel_ctrl    = hit && (word_off == 2'd2);
    assign unused_bits = ^{rel_addr[AW-1:4], rel_addr[1:0], bus.wdata[DW-1:8]};

    // A pop only happens from IDLE with data queued, so a full FIFO can still
    // accept a store on the same edge the transmitter takes the head byte.
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign pop      = (state == IDLE) && enable && !empty;
    assign push_req = bus.write && sel_txdata;
    assign push_ok  = push_req && (!full || pop);

    assign status_word = {16'b0, 8'(count), 4'b0, overflow, busy, empty, full};

    // FIFO storage needs no reset: entries are only ever read after being
    // written, as guarded by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the enable bit.
    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (bus.write && sel_status && bus.wdata[3]) begin
                overflow <= 1'b0;
            end
            if (bus.write && sel_ctrl) begin
                enable <= bus.wdata[0];
            end
        end
    end

    // Transmitter state register. Reset mid-frame abandons the frame and
    // forces the line high on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx_reg   <= tx_n;
        end
    end

    // Next-state logic. tx_n is the line level for the state being entered,
    // so the registered tx lines up exactly with the state it belongs to.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx_reg;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (pop) begin
                    shift_n    = fifo_mem[rd_ptr];
                    baud_cnt_n = '0;
                    state_n    = START;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                    tx_n       = shift[0];
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                    tx_n       = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx = tx_reg;

    // Load data is combinational and reflects pre-edge state, so a STATUS
    // read in the same cycle as a push does not yet see the new byte.
    always_comb begin
        bus.rdata = '0;
        if (bus.read && hit) begin
            case (word_off)
                2'd1:    bus.rdata = DW'(status_word);
                2'd2:    bus.rdata = DW'(enable);
                default: bus.rdata = '0;
            endcase
        end
    end

endmodule
